pipe_latch_buf: RTL and testbench

- Parametrised successor to the fixed single-entry inter-stage pipeline latch.
- Holds a DATA_W-bit stage bundle (pc_plus_4, control bits, wsel, data, etc., packed by the instantiating stage) in a DEPTH-entry in-order buffer.
- Decouples producer and consumer stages with a valid/ready handshake, and adds flush, freeze and a saturating stall counter.
- Sits between any two datapath stages; also usable as a plain one-deep latch when DEPTH=1.

---
 rtl/pipe_latch_buf.sv | 83 ++++++++
 tb/tb_pipe_latch_buf.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_latch_buf.sv
// In-order DEPTH-entry pipeline buffer between two datapath stages, with
// flush (squash to zero), freeze (global stall) and a saturating stall counter.
module pipe_latch_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       flush,
  input  logic                       freeze,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CW-1:0]     count_q;
  logic [CNT_W-1:0]  stall_q;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready depends only on registered occupancy and the
  // flush/freeze/RST inputs, never on out_ready, so a full buffer refuses a
  // push even when it is being drained in the same cycle.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign stall_cnt = stall_q;
  assign in_ready  = !full && !freeze && !flush && !RST;
  assign out_valid = !empty && !freeze;
  assign out_data  = out_valid ? mem[rptr] : '0;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !flush && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      stall_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Squashed entries are zeroed like the older fixed latches; the stall
      // history survives a flush.
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!freeze) begin
      if (push) begin
        mem[wptr] <= in_data;
        wptr      <= next_ptr(wptr);
      end
      if (pop) rptr <= next_ptr(rptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_latch_buf.sv
// Bench for pipe_latch_buf: a DEPTH=2 and a DEPTH=4/CNT_W=4 instance share
// stimulus and are each compared every cycle against a queue-based model.
module tb_pipe_latch_buf;

  logic        CLK = 1'b0;
  logic        RST, flush, freeze, in_valid, out_ready;
  logic [31:0] in_data;

  logic        d2_in_ready, d2_out_valid, d2_full, d2_empty;
  logic [31:0] d2_out_data;
  logic [1:0]  d2_count;
  logic [15:0] d2_stall;
  logic        d4_in_ready, d4_out_valid, d4_full, d4_empty;
  logic [31:0] d4_out_data;
  logic [2:0]  d4_count;
  logic [3:0]  d4_stall;

  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 CLK = ~CLK;
  initial begin
    RST = 1'b1; flush = 1'b0; freeze = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
  end

  pipe_latch_buf #(.DATA_W(32), .DEPTH(2), .CNT_W(16)) u_d2 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_data(in_data), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_data(d2_out_data), .flush(flush), .freeze(freeze),
    .count(d2_count), .full(d2_full), .empty(d2_empty), .stall_cnt(d2_stall)
  );

  pipe_latch_buf #(.DATA_W(32), .DEPTH(4), .CNT_W(4)) u_d4 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(d4_in_ready),
    .in_data(in_data), .out_valid(d4_out_valid), .out_ready(out_ready),
    .out_data(d4_out_data), .flush(flush), .freeze(freeze),
    .count(d4_count), .full(d4_full), .empty(d4_empty), .stall_cnt(d4_stall)
  );

  // reference model: one expected queue per instance, head at index 0
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          m_stall[2];
  int          m_depth[2] = '{2, 4};
  int          m_smax[2]  = '{65535, 15};
  bit          model_ok   = 1'b0;

  function automatic int msize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [31:0] mhead(input int k);
    if (msize(k) == 0) return '0;
    return (k == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    for (int k = 0; k < 2; k++) begin
      int          sz;
      bit          e_ir, e_ov;
      logic [31:0] e_od;
      sz   = msize(k);
      e_ir = (sz < m_depth[k]) && !freeze && !flush && !RST;
      e_ov = (sz > 0) && !freeze;
      e_od = e_ov ? mhead(k) : 32'h0;
      if (k == 0) begin
        chk("d2_count", 32'(d2_count), sz);
        chk("d2_full", 32'(d2_full), 32'(sz == 2));
        chk("d2_empty", 32'(d2_empty), 32'(sz == 0));
        chk("d2_in_ready", 32'(d2_in_ready), 32'(e_ir));
        chk("d2_out_valid", 32'(d2_out_valid), 32'(e_ov));
        chk("d2_out_data", d2_out_data, e_od);
        chk("d2_stall", 32'(d2_stall), m_stall[0]);
      end else begin
        chk("d4_count", 32'(d4_count), sz);
        chk("d4_full", 32'(d4_full), 32'(sz == 4));
        chk("d4_empty", 32'(d4_empty), 32'(sz == 0));
        chk("d4_in_ready", 32'(d4_in_ready), 32'(e_ir));
        chk("d4_out_valid", 32'(d4_out_valid), 32'(e_ov));
        chk("d4_out_data", d4_out_data, e_od);
        chk("d4_stall", 32'(d4_stall), m_stall[1]);
      end
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int sz;
      bit ir, ov;
      sz = msize(k);
      ir = (sz < m_depth[k]) && !freeze && !flush && !RST;
      ov = (sz > 0) && !freeze;
      if (RST || flush) begin
        if (k == 0) exp_q0.delete(); else exp_q1.delete();
        if (RST) m_stall[k] = 0;
      end else begin
        if (ov && out_ready) begin
          if (k == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        end
        if (in_valid && ir) begin
          if (k == 0) exp_q0.push_back(in_data); else exp_q1.push_back(in_data);
        end
        if (ov && !out_ready && m_stall[k] < m_smax[k]) m_stall[k]++;
      end
    end
  endtask

  // driver tasks
  task automatic drive(input bit r, input bit f, input bit z, input bit v,
                       input logic [31:0] d, input bit o);
    RST = r; flush = f; freeze = z; in_valid = v; in_data = d; out_ready = o;
    @(negedge CLK);
    if (model_ok) check_models();
  endtask

  task automatic edge_tick();
    if (RST) model_ok = 1'b1;
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input bit r, input bit f, input bit z, input bit v,
                      input logic [31:0] d, input bit o);
    drive(r, f, z, v, d, o);
    edge_tick();
  endtask

  typedef struct {
    bit          r, f, z, v;
    logic [31:0] d;
    bit          o;
    int          cnt;
    bit          full, empty, ir, ov;
    logic [31:0] od;
    int          st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit r, input bit f, input bit z, input bit v,
                              input logic [31:0] d, input bit o, input int c,
                              input bit fu, input bit em, input bit ir, input bit ov,
                              input logic [31:0] od, input int st);
    vec_t x;
    x.r = r; x.f = f; x.z = z; x.v = v; x.d = d; x.o = o;
    x.cnt = c; x.full = fu; x.empty = em; x.ir = ir; x.ov = ov; x.od = od; x.st = st;
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted, popped, cycles;

    // DEPTH=2 directed table: expected values are the outputs seen during the row
    //           r  f  z  v  d      o  cnt fu em ir ov od     st
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hA, 0, 0, 0, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hB, 0, 1, 0, 0, 1, 1, 32'hA, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hC, 0, 2, 1, 0, 0, 1, 32'hA, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 2, 1, 0, 0, 1, 32'hA, 2));
    vecs.push_back(mk(0, 1, 0, 1, 32'h7, 0, 2, 1, 0, 0, 1, 32'hA, 3));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 1, 0, 32'h0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 32'h5, 0, 0, 0, 1, 1, 0, 32'h0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 32'h6, 0, 1, 0, 0, 1, 1, 32'h5, 3));
    vecs.push_back(mk(0, 1, 0, 1, 32'h7, 0, 2, 1, 0, 0, 1, 32'h5, 4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 1, 0, 32'h0, 4));
    vecs.push_back(mk(0, 0, 0, 1, 32'h3, 1, 0, 0, 1, 1, 0, 32'h0, 4));
    vecs.push_back(mk(0, 0, 1, 1, 32'h9, 1, 1, 0, 0, 0, 0, 32'h0, 4));
    vecs.push_back(mk(0, 0, 1, 1, 32'h9, 1, 1, 0, 0, 0, 0, 32'h0, 4));
    vecs.push_back(mk(0, 0, 1, 1, 32'h9, 1, 1, 0, 0, 0, 0, 32'h0, 4));
    vecs.push_back(mk(0, 0, 0, 1, 32'h9, 1, 1, 0, 0, 1, 1, 32'h3, 4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 1, 1, 0, 0, 1, 1, 32'h9, 4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 1, 0, 32'h0, 4));

    step(1, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].f, vecs[i].z, vecs[i].v, vecs[i].d, vecs[i].o);
      chk("tbl_count", 32'(d2_count), vecs[i].cnt);
      chk("tbl_full", 32'(d2_full), 32'(vecs[i].full));
      chk("tbl_empty", 32'(d2_empty), 32'(vecs[i].empty));
      chk("tbl_in_ready", 32'(d2_in_ready), 32'(vecs[i].ir));
      chk("tbl_out_valid", 32'(d2_out_valid), 32'(vecs[i].ov));
      chk("tbl_out_data", d2_out_data, vecs[i].od);
      chk("tbl_stall", 32'(d2_stall), vecs[i].st);
      edge_tick();
    end

    // streaming: each word is the head one cycle after it is accepted
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 1, 32'(i), 1);
      chk("stream_data", d2_out_data, 32'(i));
      chk("stream_count", 32'(d2_count), 1);
    end
    step(0, 0, 0, 0, 32'h0, 1);
    chk("stream_drained", 32'(d2_empty), 1);

    // DEPTH=4 wrap-around: 10 words with random consumer gaps
    accepted = 0; popped = 0; cycles = 0;
    while ((accepted < 10 || popped < 10) && cycles < 300) begin
      bit o;
      o = ((cycles % 3) == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(0, 0, 0, accepted < 10, 32'(100 + accepted), o);
      if (d4_out_valid && out_ready) begin
        chk("wrap_order", d4_out_data, 32'(100 + popped));
        popped++;
      end
      if (in_valid && d4_in_ready) accepted++;
      edge_tick();
      cycles++;
    end
    chk("wrap_accepted", 32'(accepted), 10);
    chk("wrap_popped", 32'(popped), 10);

    // stall counter saturation at CNT_W=4, then reset mid-operation
    step(1, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 1, 32'h55, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 32'h0, 0);
    chk("sat_stall", 32'(d4_stall), 15);
    step(0, 0, 0, 0, 32'h0, 0);
    chk("sat_hold", 32'(d4_stall), 15);
    step(0, 0, 0, 1, 32'h66, 0);
    step(1, 0, 0, 0, 32'h0, 0);
    chk("rst_count", 32'(d4_count), 0);
    chk("rst_stall", 32'(d4_stall), 0);
    chk("rst_out_valid", 32'(d4_out_valid), 0);
    chk("rst_out_data", d4_out_data, 0);
    chk("rst_in_ready", 32'(d4_in_ready), 0);
    chk("rst_empty", 32'(d4_empty), 1);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
           $urandom, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
